// File: rtl/incubator_ctrl.sv
// Incubator climate controller: hysteretic IDLE/HEAT/COOL mode FSM with a minimum dwell,
// a sensor-range FAULT mode with a debounced exit, and a stepped cooler fan level.
module incubator_ctrl #(
  parameter int TW          = 8,
  parameter int RW          = 4,
  parameter int HEAT_ON     = 15,
  parameter int HEAT_OFF    = 30,
  parameter int COOL_ON     = 35,
  parameter int COOL_OFF    = 25,
  parameter int FAN_LEVELS  = 3,
  parameter int FAN_STEP    = 5,
  parameter int RPS_BASE    = 2,
  parameter int RPS_INC     = 2,
  parameter int MIN_DWELL   = 4,
  parameter int T_MIN       = -40,
  parameter int T_MAX       = 100,
  parameter int FAULT_CLEAR = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 t_valid,
  input  logic signed [TW-1:0] T,
  output logic                 heater_on,
  output logic                 cooler_on,
  output logic [RW-1:0]        cooler_rps,
  output logic [1:0]           mode,
  output logic                 fault
);

  localparam int EW = TW + 4;
  localparam int LW = $clog2(FAN_LEVELS + 1);
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int FW = $clog2(FAULT_CLEAR + 1);

  localparam logic signed [EW-1:0] P_HEAT_ON  = EW'(HEAT_ON);
  localparam logic signed [EW-1:0] P_HEAT_OFF = EW'(HEAT_OFF);
  localparam logic signed [EW-1:0] P_COOL_ON  = EW'(COOL_ON);
  localparam logic signed [EW-1:0] P_COOL_OFF = EW'(COOL_OFF);
  localparam logic signed [EW-1:0] P_FAN_STEP = EW'(FAN_STEP);
  localparam logic signed [EW-1:0] P_T_MIN    = EW'(T_MIN);
  localparam logic signed [EW-1:0] P_T_MAX    = EW'(T_MAX);
  localparam logic signed [EW-1:0] P_TWO      = EW'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COOL  = 2'b01,
    ST_HEAT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t          r_mode;
  logic [LW-1:0]   r_lvl;
  logic [DW-1:0]   r_dwell;
  logic [FW-1:0]   r_fcnt;

  state_t          w_nxt_mode;
  logic [LW-1:0]   w_nxt_lvl;
  logic [FW-1:0]   w_nxt_fcnt;
  logic [DW-1:0]   w_nxt_dwell;
  logic [RW-1:0]   w_nxt_rps;

  logic signed [EW-1:0] w_t_ext;
  logic signed [EW-1:0] w_lvl_s;
  logic signed [EW-1:0] w_up_thr;
  logic signed [EW-1:0] w_dn_thr;
  logic                 w_oor;
  logic                 w_dwell_ok;
  logic                 w_raise;
  logic                 w_lower;

  // Widened threshold arithmetic so extreme samples cannot wrap around
  assign w_t_ext    = {{4{T[TW-1]}}, T};
  assign w_lvl_s    = EW'(r_lvl);
  assign w_up_thr   = P_COOL_ON + w_lvl_s * P_FAN_STEP;
  assign w_dn_thr   = P_COOL_ON + (w_lvl_s - P_TWO) * P_FAN_STEP;
  assign w_oor      = (w_t_ext < P_T_MIN) || (w_t_ext > P_T_MAX);
  assign w_dwell_ok = (r_dwell == DW'(MIN_DWELL));
  assign w_raise    = (r_lvl < LW'(FAN_LEVELS)) && (w_t_ext > w_up_thr);
  assign w_lower    = (r_lvl >= LW'(2)) && (w_t_ext < w_dn_thr);
  assign mode       = r_mode;

  // Next-state decision: fault check first, then dwell-gated mode moves, then fan steps
  always_comb begin
    w_nxt_mode = r_mode;
    w_nxt_lvl  = r_lvl;
    w_nxt_fcnt = r_fcnt;
    if (t_valid) begin
      if (w_oor) begin
        w_nxt_mode = ST_FAULT;
        w_nxt_lvl  = LW'(0);
        w_nxt_fcnt = FW'(0);
      end else begin
        case (r_mode)
          ST_IDLE: begin
            if (w_dwell_ok && (w_t_ext < P_HEAT_ON)) begin
              w_nxt_mode = ST_HEAT;
            end else if (w_dwell_ok && (w_t_ext > P_COOL_ON)) begin
              w_nxt_mode = ST_COOL;
              w_nxt_lvl  = LW'(1);
            end else begin
              w_nxt_mode = ST_IDLE;
            end
          end
          ST_HEAT: begin
            if (w_dwell_ok && (w_t_ext > P_HEAT_OFF)) begin
              w_nxt_mode = ST_IDLE;
            end else begin
              w_nxt_mode = ST_HEAT;
            end
          end
          ST_COOL: begin
            if (w_dwell_ok && (w_t_ext < P_COOL_OFF)) begin
              w_nxt_mode = ST_IDLE;
              w_nxt_lvl  = LW'(0);
            end else if (w_raise) begin
              w_nxt_lvl = r_lvl + LW'(1);
            end else if (w_lower) begin
              w_nxt_lvl = r_lvl - LW'(1);
            end else begin
              w_nxt_lvl = r_lvl;
            end
          end
          ST_FAULT: begin
            if (r_fcnt == FW'(FAULT_CLEAR - 1)) begin
              w_nxt_mode = ST_IDLE;
              w_nxt_fcnt = FW'(0);
            end else begin
              w_nxt_fcnt = r_fcnt + FW'(1);
            end
          end
          default: begin
            w_nxt_mode = ST_IDLE;
            w_nxt_lvl  = LW'(0);
            w_nxt_fcnt = FW'(0);
          end
        endcase
      end
    end else begin
      w_nxt_mode = r_mode;
      w_nxt_lvl  = r_lvl;
      w_nxt_fcnt = r_fcnt;
    end
  end

  // Dwell counter and fan speed derived from the next state
  always_comb begin
    w_nxt_dwell = r_dwell;
    w_nxt_rps   = {RW{1'b0}};
    if (w_nxt_mode != r_mode) begin
      w_nxt_dwell = DW'(0);
    end else if (r_dwell != DW'(MIN_DWELL)) begin
      w_nxt_dwell = r_dwell + DW'(1);
    end else begin
      w_nxt_dwell = r_dwell;
    end
    if (w_nxt_lvl == LW'(0)) begin
      w_nxt_rps = {RW{1'b0}};
    end else begin
      w_nxt_rps = RW'(RPS_BASE + RPS_INC * int'(w_nxt_lvl));
    end
  end

  // State and registered actuator outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= ST_IDLE;
      r_lvl      <= LW'(0);
      r_dwell    <= DW'(0);
      r_fcnt     <= FW'(0);
      heater_on  <= 1'b0;
      cooler_on  <= 1'b0;
      cooler_rps <= {RW{1'b0}};
      fault      <= 1'b0;
    end else begin
      r_mode     <= w_nxt_mode;
      r_lvl      <= w_nxt_lvl;
      r_dwell    <= w_nxt_dwell;
      r_fcnt     <= w_nxt_fcnt;
      heater_on  <= (w_nxt_mode == ST_HEAT);
      cooler_on  <= (w_nxt_mode == ST_COOL);
      cooler_rps <= w_nxt_rps;
      fault      <= (w_nxt_mode == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_incubator_ctrl.sv
// Bench for incubator_ctrl: directed vector table, async-reset sequence and
// randomized samples checked against an integer-level behavioural model.
module tb_incubator_ctrl;

  localparam int HEAT_ON = 15, HEAT_OFF = 30, COOL_ON = 35, COOL_OFF = 25;
  localparam int FAN_LEVELS = 3, FAN_STEP = 5, RPS_BASE = 2, RPS_INC = 2;
  localparam int MIN_DWELL = 4, T_MIN = -40, T_MAX = 100, FAULT_CLEAR = 3;
  localparam int M_IDLE = 0, M_COOL = 1, M_HEAT = 2, M_FAULT = 3;

  logic              clk;
  logic              reset;
  logic              t_valid;
  logic signed [7:0] T;
  logic              heater_on;
  logic              cooler_on;
  logic [3:0]        cooler_rps;
  logic [1:0]        mode;
  logic              fault;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_mode, m_lvl, m_dwell, m_fcnt;

  typedef struct {
    bit v;
    int t;
    int exp_mode;
    int exp_rps;
  } vec_t;
  vec_t tab[$];

  incubator_ctrl dut (
    .clk(clk), .reset(reset), .t_valid(t_valid), .T(T),
    .heater_on(heater_on), .cooler_on(cooler_on), .cooler_rps(cooler_rps),
    .mode(mode), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE; m_lvl = 0; m_dwell = 0; m_fcnt = 0;
  endtask

  task automatic model_step(input bit v, input int t);
    int prev;
    prev = m_mode;
    if (v) begin
      if (t < T_MIN || t > T_MAX) begin
        m_mode = M_FAULT; m_lvl = 0; m_fcnt = 0;
      end else if (m_mode == M_FAULT) begin
        m_fcnt = m_fcnt + 1;
        if (m_fcnt == FAULT_CLEAR) begin m_mode = M_IDLE; m_fcnt = 0; end
      end else if (m_mode == M_IDLE && m_dwell == MIN_DWELL && t < HEAT_ON) begin
        m_mode = M_HEAT;
      end else if (m_mode == M_IDLE && m_dwell == MIN_DWELL && t > COOL_ON) begin
        m_mode = M_COOL; m_lvl = 1;
      end else if (m_mode == M_HEAT && m_dwell == MIN_DWELL && t > HEAT_OFF) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_COOL && m_dwell == MIN_DWELL && t < COOL_OFF) begin
        m_mode = M_IDLE; m_lvl = 0;
      end else if (m_mode == M_COOL) begin
        if (m_lvl < FAN_LEVELS && t > COOL_ON + m_lvl * FAN_STEP) m_lvl = m_lvl + 1;
        else if (m_lvl >= 2 && t < COOL_ON + (m_lvl - 2) * FAN_STEP) m_lvl = m_lvl - 1;
      end
    end
    if (m_mode != prev) m_dwell = 0;
    else if (m_dwell < MIN_DWELL) m_dwell = m_dwell + 1;
  endtask

  task automatic check_model(input string name);
    logic [8:0] act, exp;
    int rps;
    rps = (m_lvl == 0) ? 0 : RPS_BASE + RPS_INC * m_lvl;
    act = {mode, heater_on, cooler_on, cooler_rps, fault};
    exp = {2'(m_mode), m_mode == M_HEAT, m_mode == M_COOL, 4'(rps), m_mode == M_FAULT};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {mode,heat,cool,rps,fault}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input int t, input string name);
    t_valid = v;
    T = 8'(t);
    @(posedge clk);
    #1;
    model_step(v, t);
    check_model(name);
  endtask

  task automatic push(input bit v, input int t, input int m, input int r, input int n);
    vec_t e;
    e.v = v; e.t = t; e.exp_mode = m; e.exp_rps = r;
    for (int k = 0; k < n; k++) tab.push_back(e);
  endtask

  initial begin
    reset = 1'b0; t_valid = 1'b0; T = 8'sd0;
    model_reset();

    // idle/heat/idle, heat dwell, fan staging, invalid hold, fault and recovery
    push(0, 0, M_IDLE, 0, 5);
    push(1, 10, M_HEAT, 0, 1); push(1, 28, M_HEAT, 0, 1);
    push(0, 0, M_HEAT, 0, 3); push(1, 31, M_IDLE, 0, 1);
    push(1, 20, M_IDLE, 0, 4); push(1, 10, M_HEAT, 0, 1);
    push(1, 31, M_HEAT, 0, 4); push(1, 31, M_IDLE, 0, 1);
    push(0, 0, M_IDLE, 0, 4);
    push(1, 36, M_COOL, 4, 1); push(1, 50, M_COOL, 6, 1); push(1, 50, M_COOL, 8, 1);
    push(1, 38, M_COOL, 6, 1); push(1, 38, M_COOL, 6, 1); push(1, 24, M_IDLE, 0, 1);
    push(0, 0, M_IDLE, 0, 4); push(1, 36, M_COOL, 4, 1);
    for (int k = 0; k < 5; k++) begin
      push(0, 120, M_COOL, 4, 1); push(0, 0, M_COOL, 4, 1);
    end
    push(1, 24, M_IDLE, 0, 1); push(0, 0, M_IDLE, 0, 4);
    push(1, 40, M_COOL, 4, 1); push(1, 120, M_FAULT, 0, 1);
    push(1, 20, M_FAULT, 0, 2); push(1, -50, M_FAULT, 0, 1);
    push(1, 20, M_FAULT, 0, 2); push(1, 20, M_IDLE, 0, 1);
    push(0, 0, M_IDLE, 0, 4); push(1, 10, M_HEAT, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check_model("reset_state");
    reset = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].v, tab[i].t, $sformatf("model_vec%0d", i));
      n_checks++;
      if (mode !== 2'(tab[i].exp_mode) || cooler_rps !== 4'(tab[i].exp_rps)) begin
        n_errors++;
        $display("FAIL tab%0d: got mode=%0d rps=%0d expected mode=%0d rps=%0d",
                 i, mode, cooler_rps, tab[i].exp_mode, tab[i].exp_rps);
      end
    end

    // asynchronous reset asserted mid-cycle while heating
    n_checks++;
    if (heater_on !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_heat: got heater_on=%b expected 1", heater_on);
    end
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    #2 reset = 1'b1;
    step(0, 0, "post_reset_dwell0");
    step(0, 0, "post_reset_dwell1");
    step(0, 0, "post_reset_dwell2");
    step(1, 10, "post_reset_no_heat_yet");
    step(1, 10, "post_reset_heat");

    // randomized samples with bias toward thresholds and range limits
    for (int i = 0; i < 3000; i++) begin
      int t;
      bit v;
      int edge_vals[6] = '{-41, -40, -39, 99, 100, 101};
      v = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 3))
        0: t = int'($urandom_range(0, 255)) - 128;
        1: t = int'($urandom_range(10, 55));
        2: t = edge_vals[$urandom_range(0, 5)];
        default: t = int'($urandom_range(14, 40));
      endcase
      step(v, t, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
